// File: rtl/lightboard_pkg.sv
// Shared types and widths for the lightboard centroid path.
package lightboard_pkg;

    typedef enum logic {
        IDLE,
        TRACK
    } com_state_t;

    localparam int COM_X_W = 11;
    localparam int COM_Y_W = 10;

endpackage

// File: rtl/com_window.sv
// Circular window of recent centroids with running sums and rounded averages.
module com_window
    import lightboard_pkg::*;
#(
    parameter int LOG_DEPTH = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               seed,
    input  logic               insert,
    input  logic [COM_X_W-1:0] x_in,
    input  logic [COM_Y_W-1:0] y_in,
    output logic [COM_X_W-1:0] avg_x,
    output logic [COM_Y_W-1:0] avg_y,
    output logic [COM_X_W-1:0] next_avg_x,
    output logic [COM_Y_W-1:0] next_avg_y
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int SXW   = COM_X_W + LOG_DEPTH;
    localparam int SYW   = COM_Y_W + LOG_DEPTH;
    localparam int HALF  = 1 << (LOG_DEPTH - 1);

    logic [COM_X_W-1:0]   x_buf [DEPTH];
    logic [COM_Y_W-1:0]   y_buf [DEPTH];
    logic [LOG_DEPTH-1:0] ptr;
    logic [SXW-1:0]       sum_x;
    logic [SYW-1:0]       sum_y;
    logic [SXW-1:0]       sum_x_next;
    logic [SYW-1:0]       sum_y_next;

    // ptr always addresses the oldest entry, so an insert replaces it in place
    always_comb begin
        sum_x_next = sum_x;
        sum_y_next = sum_y;
        if (seed) begin
            sum_x_next = SXW'(x_in) << LOG_DEPTH;
            sum_y_next = SYW'(y_in) << LOG_DEPTH;
        end else if (insert) begin
            sum_x_next = sum_x - SXW'(x_buf[ptr]) + SXW'(x_in);
            sum_y_next = sum_y - SYW'(y_buf[ptr]) + SYW'(y_in);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                x_buf[i] <= '0;
                y_buf[i] <= '0;
            end
            ptr   <= '0;
            sum_x <= '0;
            sum_y <= '0;
        end else begin
            sum_x <= sum_x_next;
            sum_y <= sum_y_next;
            if (seed) begin
                for (int i = 0; i < DEPTH; i++) begin
                    x_buf[i] <= x_in;
                    y_buf[i] <= y_in;
                end
                ptr <= '0;
            end else if (insert) begin
                x_buf[ptr] <= x_in;
                y_buf[ptr] <= y_in;
                ptr        <= ptr + 1'b1;
            end
        end
    end

    assign avg_x      = COM_X_W'((sum_x + SXW'(HALF)) >> LOG_DEPTH);
    assign avg_y      = COM_Y_W'((sum_y + SYW'(HALF)) >> LOG_DEPTH);
    assign next_avg_x = COM_X_W'((sum_x_next + SXW'(HALF)) >> LOG_DEPTH);
    assign next_avg_y = COM_Y_W'((sum_y_next + SYW'(HALF)) >> LOG_DEPTH);

endmodule

// File: rtl/com_stabilizer.sv
// Jitter filter between center_of_mass and compare: moving average, outlier
// rejection with reacquire, and pen-up after a run of frames without a target.
module com_stabilizer
    import lightboard_pkg::*;
#(
    parameter int LOG_DEPTH      = 2,
    parameter int JUMP_MAX       = 40,
    parameter int REACQUIRE      = 3,
    parameter int TIMEOUT_FRAMES = 8,
    parameter int H_MAX          = 320,
    parameter int V_MAX          = 240
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [COM_X_W-1:0] x_com_in,
    input  logic [COM_Y_W-1:0] y_com_in,
    input  logic               com_valid_in,
    input  logic               frame_start_in,
    output logic [COM_X_W-1:0] x_com_out,
    output logic [COM_Y_W-1:0] y_com_out,
    output logic               com_valid_out,
    output logic               pen_down_out,
    output logic               busy_out
);

    localparam int OCW = $clog2(REACQUIRE + 1);
    localparam int FCW = $clog2(TIMEOUT_FRAMES + 1);

    com_state_t         state;
    logic               s1_valid;
    logic [COM_X_W-1:0] s1_x;
    logic [COM_Y_W-1:0] s1_y;
    logic [OCW-1:0]     outlier_cnt;
    logic [FCW-1:0]     frame_cnt;

    logic               accept;
    logic [COM_X_W-1:0] dx;
    logic [COM_Y_W-1:0] dy;
    logic               outlier;
    logic               reacq_hit;
    logic               seed_cmd;
    logic               insert_cmd;
    logic               timeout;
    logic [COM_X_W-1:0] avg_x;
    logic [COM_Y_W-1:0] avg_y;
    logic [COM_X_W-1:0] next_avg_x;
    logic [COM_Y_W-1:0] next_avg_y;

    assign accept = com_valid_in && !busy_out
                 && !(x_com_in == '0 && y_com_in == '0)
                 && (x_com_in < COM_X_W'(H_MAX))
                 && (y_com_in < COM_Y_W'(V_MAX));

    assign dx = (s1_x >= avg_x) ? (s1_x - avg_x) : (avg_x - s1_x);
    assign dy = (s1_y >= avg_y) ? (s1_y - avg_y) : (avg_y - s1_y);

    assign outlier    = (dx > COM_X_W'(JUMP_MAX)) || (dy > COM_Y_W'(JUMP_MAX));
    assign reacq_hit  = (int'(outlier_cnt) + 1 == REACQUIRE);
    assign seed_cmd   = s1_valid && ((state == IDLE) || (outlier && reacq_hit));
    assign insert_cmd = s1_valid && (state == TRACK) && !outlier;
    // Never time out while a sample is being accepted or decided
    assign timeout    = (state == TRACK) && (frame_cnt == FCW'(TIMEOUT_FRAMES))
                     && !s1_valid && !accept;

    com_window #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_window (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .seed       (seed_cmd),
        .insert     (insert_cmd),
        .x_in       (s1_x),
        .y_in       (s1_y),
        .avg_x      (avg_x),
        .avg_y      (avg_y),
        .next_avg_x (next_avg_x),
        .next_avg_y (next_avg_y)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            s1_valid      <= 1'b0;
            s1_x          <= '0;
            s1_y          <= '0;
            outlier_cnt   <= '0;
            frame_cnt     <= '0;
            x_com_out     <= '0;
            y_com_out     <= '0;
            com_valid_out <= 1'b0;
            pen_down_out  <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            busy_out      <= accept || s1_valid;
            s1_valid      <= accept;
            com_valid_out <= seed_cmd || insert_cmd;

            if (accept) begin
                s1_x <= x_com_in;
                s1_y <= y_com_in;
            end

            if (seed_cmd || insert_cmd) begin
                x_com_out <= next_avg_x;
                y_com_out <= next_avg_y;
            end

            if (seed_cmd || insert_cmd)
                outlier_cnt <= '0;
            else if (s1_valid && state == TRACK && outlier)
                outlier_cnt <= outlier_cnt + 1'b1;

            // An accepted sample outranks a coincident frame start
            if (accept || seed_cmd)
                frame_cnt <= '0;
            else if (state == TRACK && frame_start_in && frame_cnt != FCW'(TIMEOUT_FRAMES))
                frame_cnt <= frame_cnt + 1'b1;

            if (seed_cmd) begin
                state        <= TRACK;
                pen_down_out <= 1'b1;
            end else if (timeout) begin
                state        <= IDLE;
                pen_down_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_com_stabilizer.sv
// Directed scoreboard bench for com_stabilizer.
module tb_com_stabilizer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] x_com_in;
    logic [9:0]  y_com_in;
    logic        com_valid_in;
    logic        frame_start_in;
    logic [10:0] x_com_out;
    logic [9:0]  y_com_out;
    logic        com_valid_out;
    logic        pen_down_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] x;
        logic [9:0]  y;
    } exp_t;

    exp_t sb[$];

    always #5 clk_in = ~clk_in;

    com_stabilizer dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .x_com_in       (x_com_in),
        .y_com_in       (y_com_in),
        .com_valid_in   (com_valid_in),
        .frame_start_in (frame_start_in),
        .x_com_out      (x_com_out),
        .y_com_out      (y_com_out),
        .com_valid_out  (com_valid_out),
        .pen_down_out   (pen_down_out),
        .busy_out       (busy_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs starting at a falling edge, returns at the next one
    task automatic applyStimulus(input logic [10:0] x, input logic [9:0] y, input logic v, input logic fs);
        x_com_in       = x;
        y_com_in       = y;
        com_valid_in   = v;
        frame_start_in = fs;
        @(negedge clk_in);
        x_com_in       = '0;
        y_com_in       = '0;
        com_valid_in   = 1'b0;
        frame_start_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic sendSample(input logic [10:0] x, input logic [9:0] y, input bit pulse,
                              input logic [10:0] ex, input logic [9:0] ey);
        exp_t e;
        if (pulse) begin
            e.x = ex;
            e.y = ey;
            sb.push_back(e);
        end
        applyStimulus(x, y, 1'b1, 1'b0);
        idle(2);
    endtask

    // Every output pulse must match the oldest outstanding expectation
    always @(negedge clk_in) begin
        if (com_valid_out) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_pulse observed=%0d,%0d expected=none", x_com_out, y_com_out);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert (x_com_out === e.x && y_com_out === e.y) else begin
                    errors++;
                    $error("[TB] FAIL pulse_xy observed=%0d,%0d expected=%0d,%0d",
                           x_com_out, y_com_out, e.x, e.y);
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst_in         = 1'b1;
        x_com_in       = '0;
        y_com_in       = '0;
        com_valid_in   = 1'b0;
        frame_start_in = 1'b0;
        idle(3);
        checkOutput("rst_x", 32'(x_com_out), 32'd0);
        checkOutput("rst_y", 32'(y_com_out), 32'd0);
        checkOutput("rst_valid", 32'(com_valid_out), 32'd0);
        checkOutput("rst_pen", 32'(pen_down_out), 32'd0);
        checkOutput("rst_busy", 32'(busy_out), 32'd0);
        rst_in = 1'b0;
        idle(2);

        // Acquire with latency and busy window
        e.x = 11'd100;
        e.y = 10'd50;
        sb.push_back(e);
        applyStimulus(11'd100, 10'd50, 1'b1, 1'b0);
        checkOutput("busy_t1", 32'(busy_out), 32'd1);
        checkOutput("valid_t1", 32'(com_valid_out), 32'd0);
        idle(1);
        checkOutput("busy_t2", 32'(busy_out), 32'd1);
        checkOutput("valid_t2", 32'(com_valid_out), 32'd1);
        checkOutput("pen_t2", 32'(pen_down_out), 32'd1);
        idle(1);
        checkOutput("busy_t3", 32'(busy_out), 32'd0);
        checkOutput("hold_x", 32'(x_com_out), 32'd100);

        // Averaging with round-half-up
        sendSample(11'd104, 10'd50, 1'b1, 11'd101, 10'd50);
        sendSample(11'd106, 10'd51, 1'b1, 11'd103, 10'd50);

        // Outlier rejection and reseed on the third
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        sendSample(11'd100, 10'd50, 1'b1, 11'd100, 10'd50);
        sendSample(11'd200, 10'd50, 1'b0, 11'd0, 10'd0);
        sendSample(11'd200, 10'd50, 1'b0, 11'd0, 10'd0);
        checkOutput("outlier_hold_x", 32'(x_com_out), 32'd100);
        sendSample(11'd200, 10'd50, 1'b1, 11'd200, 10'd50);
        sendSample(11'd204, 10'd50, 1'b1, 11'd201, 10'd50);

        // Filtering: zero, out of range, and a valid while busy
        sendSample(11'd0, 10'd0, 1'b0, 11'd0, 10'd0);
        sendSample(11'd320, 10'd10, 1'b0, 11'd0, 10'd0);
        sendSample(11'd10, 10'd240, 1'b0, 11'd0, 10'd0);
        e.x = 11'd201;
        e.y = 10'd50;
        sb.push_back(e);
        applyStimulus(11'd201, 10'd50, 1'b1, 1'b0);
        applyStimulus(11'd202, 10'd50, 1'b1, 1'b0);
        idle(1);
        checkOutput("filter_pen", 32'(pen_down_out), 32'd1);

        // An in-track sample clears the outlier count
        sendSample(11'd10, 10'd10, 1'b0, 11'd0, 10'd0);
        sendSample(11'd10, 10'd10, 1'b0, 11'd0, 10'd0);
        sendSample(11'd201, 10'd50, 1'b1, 11'd202, 10'd50);
        sendSample(11'd10, 10'd10, 1'b0, 11'd0, 10'd0);
        sendSample(11'd10, 10'd10, 1'b0, 11'd0, 10'd0);
        sendSample(11'd10, 10'd10, 1'b1, 11'd10, 10'd10);

        // Timeout: a frame start coincident with a sample does not count
        repeat (5) applyStimulus(11'd0, 10'd0, 1'b0, 1'b1);
        e.x = 11'd10;
        e.y = 10'd10;
        sb.push_back(e);
        applyStimulus(11'd11, 10'd10, 1'b1, 1'b1);
        idle(2);
        repeat (7) applyStimulus(11'd0, 10'd0, 1'b0, 1'b1);
        idle(3);
        checkOutput("pen_after_7", 32'(pen_down_out), 32'd1);
        applyStimulus(11'd0, 10'd0, 1'b0, 1'b1);
        idle(3);
        checkOutput("pen_after_8", 32'(pen_down_out), 32'd0);
        checkOutput("timeout_hold_x", 32'(x_com_out), 32'd10);
        checkOutput("timeout_hold_y", 32'(y_com_out), 32'd10);
        sendSample(11'd30, 10'd30, 1'b1, 11'd30, 10'd30);
        checkOutput("pen_reacquire", 32'(pen_down_out), 32'd1);

        // Reset while a sample is in flight
        applyStimulus(11'd50, 10'd60, 1'b1, 1'b0);
        rst_in = 1'b1;
        idle(1);
        rst_in = 1'b0;
        checkOutput("midrst_valid", 32'(com_valid_out), 32'd0);
        checkOutput("midrst_x", 32'(x_com_out), 32'd0);
        checkOutput("midrst_pen", 32'(pen_down_out), 32'd0);
        checkOutput("midrst_busy", 32'(busy_out), 32'd0);
        idle(2);
        sendSample(11'd100, 10'd50, 1'b1, 11'd100, 10'd50);

        idle(4);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
